ni_target_resp_router: RTL
==========================

Name: ni_target_resp_router

Overview:
- Response-side counterpart of the initiator routing LUT. Sits in a target NI between the request depacketizer and the response packetizer.
- On each accepted request that needs a response, it looks up the return path to the originating initiator and queues {path, initiator id, tag} in order.
- When the slave returns a response, it pops the head entry and presents a registered response header (path, target, tag, error) to the packetizer.

Parameters:
- SRC_ID_WIDTH, 4, width of initiator id (response transaction_target).
- PATH_WIDTH, 7, route width; first hop in the LSBs, last hop in the MSBs.
- TAG_WIDTH, 4, transaction tag width.
- DEPTH, 4, outstanding-response FIFO entries (power of two, at least 2).
- TIMEOUT_CYCLES, 255, watchdog limit (optional feature only).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request header valid
- req_ready  out  1  request may be accepted
- req_src_id  in  SRC_ID_WIDTH  originating initiator id
- req_tag  in  TAG_WIDTH  transaction tag
- req_needs_resp  in  1  0 = posted write, no response expected
- resp_valid  in  1  slave response available
- resp_ready  out  1  response consumed this cycle
- resp_error  in  1  slave error flag
- hdr_valid  out  1  response header valid
- hdr_ready  in  1  packetizer accepts header
- hdr_path  out  PATH_WIDTH  return route
- hdr_target  out  SRC_ID_WIDTH  destination initiator id
- hdr_tag  out  TAG_WIDTH  echoed tag
- hdr_error  out  1  response error
- decode_err  out  1  sticky: a response was dropped for an unknown source
- outstanding  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Clocking and reset: one clock, clock. reset is synchronous and active-high.
- Reset values: hdr_valid=0, hdr_path=0, hdr_target=0, hdr_tag=0, hdr_error=0, decode_err=0, outstanding=0. FIFO pointers are cleared and in-flight entries are discarded. Reset mid-transaction drops everything.
- Lookup (combinational, evaluated on req_src_id):
  - 0x0 -> 7'b0000010
  - 0x1 -> 7'b0000001
  - 0x3 -> 7'b0000111
  - 0x5 -> 7'b0000011
  - any other id -> path 0, bad=1
- Request handshake:
  - req_ready = !full.
  - Accept when req_valid && req_ready.
  - If req_needs_resp=1, push {path, src_id, tag, bad}. If 0, the request is accepted with no push.
  - When full, req_ready=0. A pop in the same cycle does not raise req_ready until the next cycle.
- Response handshake:
  - resp_ready = !empty && (!hdr_valid || hdr_ready). There is no empty bypass: a push and a response in the same cycle with an empty FIFO stalls the response by one cycle.
  - A stray response while the FIFO is empty stalls indefinitely.
- On resp_valid && resp_ready:
  - Pop the head entry.
  - If head.bad=0: load the hdr_* registers next edge with hdr_error=resp_error and set hdr_valid=1. Latency is 1 cycle.
  - If head.bad=1: no header is produced, and decode_err is set (sticky until reset).
- hdr_valid clears on hdr_ready unless a new header loads in the same cycle. Back-to-back headers run at full throughput when hdr_ready=1.
- Header fields stay stable while hdr_valid && !hdr_ready.
- outstanding:
  - +1 on push, -1 on pop.
  - Unchanged on simultaneous push and pop.
  - Pointers wrap modulo DEPTH, and full/empty are derived from the count.

Optional Feature:
- NI_TARGET_RESP_TIMEOUT_EN defined:
  - An 8-bit-or-wider watchdog counts cycles while the FIFO is non-empty and no pop occurs. It resets on every pop or when the FIFO is empty.
  - When the count reaches TIMEOUT_CYCLES and the output register is free, the head is popped as a synthesized header with hdr_error=1 (bad entries are dropped as above). The counter then restarts.
  - A real response arriving in the same cycle takes priority.
- Undefined: no counter; the head waits indefinitely.

Decomposition:
- Shared package/header (alongside noc_parameters.v): entry layout {bad, path, src_id, tag}, the width defines, and the unknown-source path constant 0.
- One sub-module, ni_target_return_lookup: the purely combinational src_id -> {path, bad} table, generated per topology.

Test Plan:
- Reset, then req src=0x1 tag=0x3 needs_resp=1, then resp error=0 -> one cycle later hdr_valid=1, path=7'b0000001, target=0x1, tag=0x3, error=0.
- 4 requests (src 0,1,3,5), 5th req_valid -> req_ready=0 and outstanding=4; then 4 responses with hdr_ready=1 -> paths 0000010, 0000001, 0000111, 0000011 in order on consecutive cycles.
- Req src=0x9 needs_resp=1, then resp -> no hdr_valid, decode_err=1 and remains 1 until reset.
- Req needs_resp=0 -> outstanding stays 0 and resp_ready=0 while resp_valid=1.
- hdr_ready=0 for 3 cycles with 2 queued responses -> header held stable and resp_ready=0; on hdr_ready=1 the second header follows the next cycle.
- With NI_TARGET_RESP_TIMEOUT_EN, TIMEOUT_CYCLES=8: req src=0x3, no resp -> hdr_valid with error=1, path=7'b0000111, after 8 cycles; mid-test reset -> all outputs zero.

Source files
------------

// File: rtl/ni_target_resp_router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ni_target_resp_router_pkg
// Description : Shared definitions for the target-NI response router:
//               default widths, queued entry layout and the unknown-source
//               path constant.
//               Entry layout (MSB..LSB): {bad, path, src_id, tag}.
// Revision    : 1.0 - initial release
// ============================================================================
package ni_target_resp_router_pkg;

  localparam int DEF_SRC_ID_WIDTH   = 4;
  localparam int DEF_PATH_WIDTH     = 7;
  localparam int DEF_TAG_WIDTH      = 4;
  localparam int DEF_DEPTH          = 4;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  // Route reported for a source id that has no entry in the return table
  localparam int UNKNOWN_PATH = 0;

  // Watchdog counter is never narrower than this
  localparam int WD_MIN_WIDTH = 8;

  // Width of one queued entry {bad, path, src_id, tag}
  function automatic int entry_width(input int path_w, input int src_w, input int tag_w);
    return 1 + path_w + src_w + tag_w;
  endfunction

endpackage : ni_target_resp_router_pkg
`default_nettype wire

// File: rtl/ni_target_return_lookup.sv
`default_nettype none
// ============================================================================
// Module      : ni_target_return_lookup
// Description : Combinational table mapping an originating initiator id to
//               the return route towards it. Unknown ids yield path 0 and
//               bad=1. Regenerated per NoC topology.
// Revision    : 1.0 - initial release
// ============================================================================
module ni_target_return_lookup
  import ni_target_resp_router_pkg::*;
#(
  parameter int SRC_ID_WIDTH = DEF_SRC_ID_WIDTH,
  parameter int PATH_WIDTH   = DEF_PATH_WIDTH
) (
  input  logic [SRC_ID_WIDTH-1:0] src_id_i,
  output logic [PATH_WIDTH-1:0]   path_o,
  output logic                    bad_o
);

  // Route table: first hop in the LSBs, last hop in the MSBs
  always_comb begin
    path_o = PATH_WIDTH'(UNKNOWN_PATH);
    bad_o  = 1'b0;
    case (src_id_i)
      SRC_ID_WIDTH'(0): path_o = PATH_WIDTH'(7'b0000010);
      SRC_ID_WIDTH'(1): path_o = PATH_WIDTH'(7'b0000001);
      SRC_ID_WIDTH'(3): path_o = PATH_WIDTH'(7'b0000111);
      SRC_ID_WIDTH'(5): path_o = PATH_WIDTH'(7'b0000011);
      default:          bad_o  = 1'b1;
    endcase
  end

endmodule : ni_target_return_lookup
`default_nettype wire

// File: rtl/ni_target_resp_router.sv
`default_nettype none
// ============================================================================
// Module      : ni_target_resp_router
// Description : Target-NI response router. Queues {bad, path, src, tag} for
//               every request expecting a response and, as the slave answers,
//               pops the head and presents a registered response header.
//               Entries for unknown sources are dropped and flag decode_err.
//               Optional feature macro: NI_TARGET_RESP_TIMEOUT_EN - watchdog
//               that synthesizes an error response for a stalled head entry.
// Revision    : 1.0 - initial release
// ============================================================================
module ni_target_resp_router
  import ni_target_resp_router_pkg::*;
#(
  parameter int SRC_ID_WIDTH   = DEF_SRC_ID_WIDTH,
  parameter int PATH_WIDTH     = DEF_PATH_WIDTH,
  parameter int TAG_WIDTH      = DEF_TAG_WIDTH,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [SRC_ID_WIDTH-1:0]      req_src_id_i,
  input  logic [TAG_WIDTH-1:0]         req_tag_i,
  input  logic                         req_needs_resp_i,
  input  logic                         resp_valid_i,
  output logic                         resp_ready_o,
  input  logic                         resp_error_i,
  output logic                         hdr_valid_o,
  input  logic                         hdr_ready_i,
  output logic [PATH_WIDTH-1:0]        hdr_path_o,
  output logic [SRC_ID_WIDTH-1:0]      hdr_target_o,
  output logic [TAG_WIDTH-1:0]         hdr_tag_o,
  output logic                         hdr_error_o,
  output logic                         decode_err_o,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding_o
);

  localparam int CNT_W    = $clog2(DEPTH + 1);
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int ENTRY_W  = entry_width(PATH_WIDTH, SRC_ID_WIDTH, TAG_WIDTH);
  localparam int SRC_LSB  = TAG_WIDTH;
  localparam int PATH_LSB = TAG_WIDTH + SRC_ID_WIDTH;
  localparam int BAD_BIT  = ENTRY_W - 1;

  // Outstanding-response storage and bookkeeping
  logic [ENTRY_W-1:0]      mem_q [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;

  // Response header output register
  logic                    hdr_valid_q, hdr_valid_d;
  logic [PATH_WIDTH-1:0]   hdr_path_q, hdr_path_d;
  logic [SRC_ID_WIDTH-1:0] hdr_target_q, hdr_target_d;
  logic [TAG_WIDTH-1:0]    hdr_tag_q, hdr_tag_d;
  logic                    hdr_error_q, hdr_error_d;
  logic                    decode_err_q, decode_err_d;

  logic [PATH_WIDTH-1:0]   lk_path;
  logic                    lk_bad;
  logic [ENTRY_W-1:0]      head;
  logic                    full, empty, out_free;
  logic                    push, pop_resp, pop_timeout, pop;

  ni_target_return_lookup #(
    .SRC_ID_WIDTH (SRC_ID_WIDTH),
    .PATH_WIDTH   (PATH_WIDTH)
  ) u_lookup (
    .src_id_i (req_src_id_i),
    .path_o   (lk_path),
    .bad_o    (lk_bad)
  );

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign head     = mem_q[rd_ptr_q];
  // Output register can take a new header this cycle
  assign out_free = !hdr_valid_q || hdr_ready_i;

  assign req_ready_o  = !full;
  assign resp_ready_o = !empty && out_free;

  assign push     = req_valid_i && req_ready_o && req_needs_resp_i;
  assign pop_resp = resp_valid_i && resp_ready_o;
  assign pop      = pop_resp || pop_timeout;

`ifdef NI_TARGET_RESP_TIMEOUT_EN
  localparam int WD_NEED = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WD_W    = (WD_NEED > WD_MIN_WIDTH) ? WD_NEED : WD_MIN_WIDTH;

  logic [WD_W-1:0] wd_q, wd_d;

  // A real response in the same cycle always wins over the watchdog
  assign pop_timeout = (wd_q >= WD_W'(TIMEOUT_CYCLES)) && !empty && out_free && !pop_resp;

  // Watchdog: count stalled cycles of a non-empty queue, saturating at the limit
  always_comb begin
    wd_d = wd_q;
    if (pop || empty) begin
      wd_d = '0;
    end else if (wd_q < WD_W'(TIMEOUT_CYCLES)) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  // Watchdog register
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |32'(TIMEOUT_CYCLES);
  assign pop_timeout        = 1'b0;
`endif

  // Queue pointer and occupancy next state; pointers wrap since DEPTH is 2^n
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Header register next state: load on a good pop, otherwise drain on ready
  always_comb begin
    hdr_valid_d  = hdr_valid_q;
    hdr_path_d   = hdr_path_q;
    hdr_target_d = hdr_target_q;
    hdr_tag_d    = hdr_tag_q;
    hdr_error_d  = hdr_error_q;
    decode_err_d = decode_err_q;
    if (pop && !head[BAD_BIT]) begin
      hdr_valid_d  = 1'b1;
      hdr_path_d   = head[PATH_LSB +: PATH_WIDTH];
      hdr_target_d = head[SRC_LSB +: SRC_ID_WIDTH];
      hdr_tag_d    = head[0 +: TAG_WIDTH];
      hdr_error_d  = pop_resp ? resp_error_i : 1'b1;
    end else if (hdr_ready_i) begin
      hdr_valid_d  = 1'b0;
    end
    if (pop && head[BAD_BIT]) begin
      decode_err_d = 1'b1;
    end
  end

  // Entry storage; stale contents are harmless once pointers are cleared
  always_ff @(posedge clock_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {lk_bad, lk_path, req_src_id_i, req_tag_i};
    end
  end

  // Control and header state registers
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      hdr_valid_q  <= 1'b0;
      hdr_path_q   <= '0;
      hdr_target_q <= '0;
      hdr_tag_q    <= '0;
      hdr_error_q  <= 1'b0;
      decode_err_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      hdr_valid_q  <= hdr_valid_d;
      hdr_path_q   <= hdr_path_d;
      hdr_target_q <= hdr_target_d;
      hdr_tag_q    <= hdr_tag_d;
      hdr_error_q  <= hdr_error_d;
      decode_err_q <= decode_err_d;
    end
  end

  assign hdr_valid_o   = hdr_valid_q;
  assign hdr_path_o    = hdr_path_q;
  assign hdr_target_o  = hdr_target_q;
  assign hdr_tag_o     = hdr_tag_q;
  assign hdr_error_o   = hdr_error_q;
  assign decode_err_o  = decode_err_q;
  assign outstanding_o = count_q;

endmodule : ni_target_resp_router
`default_nettype wire
